// File: rtl/sat_cnf_stream_eval_if.sv
// Literal stream bundle between the formula literal store (master) and the CNF evaluator (slave).
// One literal moves on every cycle where lit_valid and lit_ready are both high.
interface sat_cnf_stream_eval_if #(
  parameter int unsigned VAR_IDX_W = 6
);
  logic                 lit_valid;
  logic                 lit_ready;
  logic [VAR_IDX_W-1:0] lit_var;
  logic                 lit_neg;
  logic                 lit_last;
  logic                 lit_eof;

  modport master (
    output lit_valid, lit_var, lit_neg, lit_last, lit_eof,
    input  lit_ready
  );

  modport slave (
    input  lit_valid, lit_var, lit_neg, lit_last, lit_eof,
    output lit_ready
  );
endinterface

// File: rtl/sat_cnf_stream_eval.sv
// Streaming CNF evaluator: checks a literal stream against a stored truth assignment and
// reports SAT/UNSAT, the first false clause and clause counters.
module sat_cnf_stream_eval #(
  parameter int unsigned          NUM_VARS    = 32,
  parameter int unsigned          VAR_IDX_W   = 6,
  parameter int unsigned          CNT_W       = 16,
  parameter logic [NUM_VARS-1:0]  INIT_ASSIGN = '0,
  parameter int unsigned          EARLY_EXIT  = 0
) (
  input  logic                 clk,
  input  logic                 resetClause,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 assign_we_i,
  input  logic [NUM_VARS-1:0]  assign_data_i,
  sat_cnf_stream_eval_if.slave lit,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_o,
  output logic [CNT_W-1:0]     first_unsat_o,
  output logic [CNT_W-1:0]     clause_cnt_o,
  output logic [CNT_W-1:0]     unsat_cnt_o,
  output logic                 idx_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EVAL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [VAR_IDX_W:0] NumVarsExt = (VAR_IDX_W + 1)'(NUM_VARS);
  localparam logic [CNT_W-1:0]   CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CntMax     = {CNT_W{1'b1}};
  localparam bit                 EarlyExit  = (EARLY_EXIT != 0);

  logic [1:0]          state_q,     state_d;
  logic [NUM_VARS-1:0] assign_q,    assign_d;
  logic                clauseAcc_q, clauseAcc_d;
  logic                cnfAcc_q,    cnfAcc_d;
  logic                sat_q,       sat_d;
  logic [CNT_W-1:0]    firstUnsat_q, firstUnsat_d;
  logic [CNT_W-1:0]    clauseCnt_q, clauseCnt_d;
  logic [CNT_W-1:0]    unsatCnt_q,  unsatCnt_d;
  logic                idxErr_q,    idxErr_d;

  logic                busy;
  logic                fire;
  logic                isLast;
  logic                inRange;
  logic                litVal;
  logic                accNext;
  logic [VAR_IDX_W-1:0] litVar;
  logic [NUM_VARS-1:0] shifted;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] x);
    return (x == CntMax) ? x : x + CntOne;
  endfunction

  assign busy          = (state_q == ST_EVAL) || (state_q == ST_DRAIN);
  assign lit.lit_ready = busy;
  assign fire          = lit.lit_valid && busy;
  assign isLast        = lit.lit_last || lit.lit_eof;
  assign litVar        = lit.lit_var;

  // Out-of-range indices read as a false literal; the shift keeps the select width-safe.
  always_comb begin
    shifted = assign_q >> litVar;
    inRange = ({1'b0, litVar} < NumVarsExt);
    litVal  = inRange && (shifted[0] ^ lit.lit_neg);
    accNext = clauseAcc_q | litVal;
  end

  always_comb begin
    state_d      = state_q;
    assign_d     = assign_q;
    clauseAcc_d  = clauseAcc_q;
    cnfAcc_d     = cnfAcc_q;
    sat_d        = sat_q;
    firstUnsat_d = firstUnsat_q;
    clauseCnt_d  = clauseCnt_q;
    unsatCnt_d   = unsatCnt_q;
    idxErr_d     = idxErr_q;

    if (abort_i) begin
      state_d     = ST_IDLE;
      sat_d       = 1'b0;
      clauseAcc_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (assign_we_i) assign_d = assign_data_i;
          if (start_i) begin
            state_d      = ST_EVAL;
            sat_d        = 1'b0;
            clauseAcc_d  = 1'b0;
            cnfAcc_d     = 1'b1;
            firstUnsat_d = '0;
            clauseCnt_d  = '0;
            unsatCnt_d   = '0;
            idxErr_d     = 1'b0;
          end
        end
        ST_EVAL: begin
          if (fire) begin
            if (!inRange) idxErr_d = 1'b1;
            if (isLast) begin
              clauseAcc_d = 1'b0;
              clauseCnt_d = satInc(clauseCnt_q);
              if (!accNext) begin
                unsatCnt_d = satInc(unsatCnt_q);
                cnfAcc_d   = 1'b0;
                // cnfAcc still high means no clause has failed yet in this run.
                if (cnfAcc_q) firstUnsat_d = clauseCnt_q;
              end
              if (lit.lit_eof) begin
                state_d = ST_DONE;
                sat_d   = cnfAcc_q && accNext;
              end else if (!accNext && EarlyExit) begin
                state_d = ST_DRAIN;
              end
            end else begin
              clauseAcc_d = accNext;
            end
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            if (isLast) clauseCnt_d = satInc(clauseCnt_q);
            if (lit.lit_eof) begin
              state_d = ST_DONE;
              sat_d   = cnfAcc_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetClause) begin
    if (!resetClause) begin
      state_q      <= ST_IDLE;
      assign_q     <= INIT_ASSIGN;
      clauseAcc_q  <= 1'b0;
      cnfAcc_q     <= 1'b1;
      sat_q        <= 1'b0;
      firstUnsat_q <= '0;
      clauseCnt_q  <= '0;
      unsatCnt_q   <= '0;
      idxErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      assign_q     <= assign_d;
      clauseAcc_q  <= clauseAcc_d;
      cnfAcc_q     <= cnfAcc_d;
      sat_q        <= sat_d;
      firstUnsat_q <= firstUnsat_d;
      clauseCnt_q  <= clauseCnt_d;
      unsatCnt_q   <= unsatCnt_d;
      idxErr_q     <= idxErr_d;
    end
  end

  assign busy_o        = busy;
  assign done_o        = (state_q == ST_DONE);
  assign sat_o         = sat_q;
  assign first_unsat_o = firstUnsat_q;
  assign clause_cnt_o  = clauseCnt_q;
  assign unsat_cnt_o   = unsatCnt_q;
  assign idx_err_o     = idxErr_q;

endmodule

// File: tb/tb_sat_cnf_stream_eval.sv
// Directed bench: dut0 runs full evaluation, dut1 early-exit; both see the same literal stream.
// Result vectors are {done, sat, first_unsat, clause_cnt, unsat_cnt, idx_err}.
module tb_sat_cnf_stream_eval;

  logic        clk = 1'b0;
  logic        resetClause;
  logic        start, abort, assignWe;
  logic [31:0] assignData;

  logic        busy0, done0, sat0, idxErr0;
  logic        busy1, done1, sat1, idxErr1;
  logic [15:0] firstUnsat0, clauseCnt0, unsatCnt0;
  logic [15:0] firstUnsat1, clauseCnt1, unsatCnt1;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [50:0] expRes;

  sat_cnf_stream_eval_if #(.VAR_IDX_W(6)) lit0 ();
  sat_cnf_stream_eval_if #(.VAR_IDX_W(6)) lit1 ();

  sat_cnf_stream_eval #(.NUM_VARS(32), .VAR_IDX_W(6), .CNT_W(16),
                        .INIT_ASSIGN(32'h0000_0002), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .resetClause(resetClause), .start_i(start), .abort_i(abort),
    .assign_we_i(assignWe), .assign_data_i(assignData), .lit(lit0.slave),
    .busy_o(busy0), .done_o(done0), .sat_o(sat0), .first_unsat_o(firstUnsat0),
    .clause_cnt_o(clauseCnt0), .unsat_cnt_o(unsatCnt0), .idx_err_o(idxErr0)
  );

  sat_cnf_stream_eval #(.NUM_VARS(32), .VAR_IDX_W(6), .CNT_W(16),
                        .INIT_ASSIGN(32'h0000_0002), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .resetClause(resetClause), .start_i(start), .abort_i(abort),
    .assign_we_i(assignWe), .assign_data_i(assignData), .lit(lit1.slave),
    .busy_o(busy1), .done_o(done1), .sat_o(sat1), .first_unsat_o(firstUnsat1),
    .clause_cnt_o(clauseCnt1), .unsat_cnt_o(unsatCnt1), .idx_err_o(idxErr1)
  );

  wire [50:0] res0 = {done0, sat0, firstUnsat0, clauseCnt0, unsatCnt0, idxErr0};
  wire [50:0] res1 = {done1, sat1, firstUnsat1, clauseCnt1, unsatCnt1, idxErr1};

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task sendLit(input logic [5:0] v, input logic n, input logic l, input logic e);
    lit0.lit_valid = 1'b1; lit0.lit_var = v; lit0.lit_neg = n; lit0.lit_last = l; lit0.lit_eof = e;
    lit1.lit_valid = 1'b1; lit1.lit_var = v; lit1.lit_neg = n; lit1.lit_last = l; lit1.lit_eof = e;
    tick();
  endtask

  task idleLit;
    lit0.lit_valid = 1'b0; lit0.lit_last = 1'b0; lit0.lit_eof = 1'b0;
    lit1.lit_valid = 1'b0; lit1.lit_last = 1'b0; lit1.lit_eof = 1'b0;
  endtask

  task startRun;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task loadAssign(input logic [31:0] d);
    assignWe = 1'b1; assignData = d;
    tick();
    assignWe = 1'b0;
  endtask

  task test_reset;
    resetClause = 1'b0;
    tick(); tick();
    assertCount++;
    if ({lit0.lit_ready, busy0, lit1.lit_ready, busy1} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_ready_busy: got %b expected 0000", {lit0.lit_ready, busy0, lit1.lit_ready, busy1});
    end
    assertCount++;
    if ((res0 !== 51'd0) || (res1 !== 51'd0)) begin
      failCount++;
      $display("[TB] FAIL reset_results: got %h / %h expected 0", res0, res1);
    end
    resetClause = 1'b1;
    tick();
  endtask

  task test_sat_formula;
    loadAssign(32'h0000_0005);
    startRun();
    assertCount++;
    if ({lit0.lit_ready, busy0, done0} !== 3'b110) begin
      failCount++;
      $display("[TB] FAIL sat_eval_entry: got %b expected 110", {lit0.lit_ready, busy0, done0});
    end
    sendLit(6'd0, 1'b0, 1'b0, 1'b0);
    sendLit(6'd1, 1'b0, 1'b1, 1'b0);
    sendLit(6'd1, 1'b1, 1'b0, 1'b0);
    sendLit(6'd2, 1'b0, 1'b1, 1'b0);
    sendLit(6'd2, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (done0 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sat_done_early: got %b expected 0", done0);
    end
    sendLit(6'd3, 1'b1, 1'b1, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b1, 16'd0, 16'd3, 16'd0, 1'b0};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL sat_result_dut0: got %h expected %h", res0, expRes);
    end
    assertCount++;
    if (res1 !== expRes) begin
      failCount++;
      $display("[TB] FAIL sat_result_dut1: got %h expected %h", res1, expRes);
    end
  endtask

  task test_unsat_and_early_exit;
    loadAssign(32'h0000_0000);
    startRun();
    sendLit(6'd0, 1'b0, 1'b1, 1'b0);
    assertCount++;
    if ({busy1, lit1.lit_ready, clauseCnt1, unsatCnt1} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
      failCount++;
      $display("[TB] FAIL early_exit_drain: got busy=%b ready=%b cnt=%0d unsat=%0d expected 1 1 1 1",
               busy1, lit1.lit_ready, clauseCnt1, unsatCnt1);
    end
    sendLit(6'd0, 1'b1, 1'b1, 1'b0);
    sendLit(6'd1, 1'b0, 1'b1, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b0, 16'd0, 16'd3, 16'd2, 1'b0};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL unsat_result_dut0: got %h expected %h", res0, expRes);
    end
    expRes = {1'b1, 1'b0, 16'd0, 16'd3, 16'd1, 1'b0};
    assertCount++;
    if (res1 !== expRes) begin
      failCount++;
      $display("[TB] FAIL early_exit_result_dut1: got %h expected %h", res1, expRes);
    end
  endtask

  task test_backpressure_idx;
    loadAssign(32'h0000_0005);
    startRun();
    sendLit(6'd0, 1'b0, 1'b1, 1'b0);
    sendLit(6'd1, 1'b0, 1'b0, 1'b0);
    idleLit();
    tick(); tick();
    assertCount++;
    if ({busy0, clauseCnt0, unsatCnt0} !== {1'b1, 16'd1, 16'd0}) begin
      failCount++;
      $display("[TB] FAIL gap_hold: got busy=%b cnt=%0d unsat=%0d expected 1 1 0", busy0, clauseCnt0, unsatCnt0);
    end
    sendLit(6'd0, 1'b1, 1'b1, 1'b0);
    sendLit(6'd40, 1'b0, 1'b0, 1'b0);
    idleLit();
    tick();
    assertCount++;
    if ({idxErr0, idxErr1} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL idx_err_set: got %b expected 10", {idxErr0, idxErr1});
    end
    sendLit(6'd2, 1'b0, 1'b0, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b0, 16'd1, 16'd3, 16'd1, 1'b1};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL bp_result_dut0: got %h expected %h", res0, expRes);
    end
    expRes = {1'b1, 1'b0, 16'd1, 16'd3, 16'd1, 1'b0};
    assertCount++;
    if (res1 !== expRes) begin
      failCount++;
      $display("[TB] FAIL bp_result_dut1: got %h expected %h", res1, expRes);
    end
    tick(); tick();
    assertCount++;
    if (idxErr0 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL idx_err_sticky: got %b expected 1", idxErr0);
    end
  endtask

  task test_control;
    startRun();
    assertCount++;
    if ({busy0, res0} !== {1'b1, 51'd0}) begin
      failCount++;
      $display("[TB] FAIL restart_clear: got busy=%b res=%h expected 1 0", busy0, res0);
    end
    assignWe = 1'b1; assignData = 32'h0000_0000;
    tick();
    assignWe = 1'b0;
    sendLit(6'd0, 1'b0, 1'b0, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b1, 16'd0, 16'd1, 16'd0, 1'b0};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL assign_we_busy_ignored: got %h expected %h", res0, expRes);
    end
    assignWe = 1'b1; assignData = 32'h0000_0000; start = 1'b1;
    tick();
    assignWe = 1'b0; start = 1'b0;
    sendLit(6'd0, 1'b0, 1'b0, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b0, 16'd0, 16'd1, 16'd1, 1'b0};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL assign_with_start: got %h expected %h", res0, expRes);
    end
    startRun();
    sendLit(6'd0, 1'b0, 1'b1, 1'b0);
    idleLit();
    start = 1'b1;
    tick();
    start = 1'b0;
    assertCount++;
    if ({busy0, clauseCnt0, unsatCnt0} !== {1'b1, 16'd1, 16'd1}) begin
      failCount++;
      $display("[TB] FAIL start_while_busy: got busy=%b cnt=%0d unsat=%0d expected 1 1 1", busy0, clauseCnt0, unsatCnt0);
    end
    sendLit(6'd1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    sendLit(6'd2, 1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    idleLit();
    assertCount++;
    if ({busy0, lit0.lit_ready, busy1, lit1.lit_ready} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL abort_idle: got %b expected 0000", {busy0, lit0.lit_ready, busy1, lit1.lit_ready});
    end
    expRes = {1'b0, 1'b0, 16'd0, 16'd1, 16'd1, 1'b0};
    assertCount++;
    if ((res0 !== expRes) || (res1 !== expRes)) begin
      failCount++;
      $display("[TB] FAIL abort_retain: got %h / %h expected %h", res0, res1, expRes);
    end
    startRun();
    sendLit(6'd0, 1'b1, 1'b0, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b1, 16'd0, 16'd1, 16'd0, 1'b0};
    assertCount++;
    if (res0 !== expRes) begin
      failCount++;
      $display("[TB] FAIL restart_after_abort: got %h expected %h", res0, expRes);
    end
  endtask

  task test_reset_mid_eval;
    startRun();
    sendLit(6'd0, 1'b0, 1'b0, 1'b0);
    idleLit();
    #2 resetClause = 1'b0;
    #1;
    assertCount++;
    if ({busy0, lit0.lit_ready, busy1, lit1.lit_ready} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL async_reset_ready: got %b expected 0000", {busy0, lit0.lit_ready, busy1, lit1.lit_ready});
    end
    assertCount++;
    if ((res0 !== 51'd0) || (res1 !== 51'd0)) begin
      failCount++;
      $display("[TB] FAIL async_reset_results: got %h / %h expected 0", res0, res1);
    end
    tick();
    resetClause = 1'b1;
    tick();
    startRun();
    sendLit(6'd1, 1'b0, 1'b1, 1'b0);
    sendLit(6'd0, 1'b1, 1'b1, 1'b1);
    idleLit();
    expRes = {1'b1, 1'b1, 16'd0, 16'd2, 16'd0, 1'b0};
    assertCount++;
    if ((res0 !== expRes) || (res1 !== expRes)) begin
      failCount++;
      $display("[TB] FAIL init_assign_restored: got %h / %h expected %h", res0, res1, expRes);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; assignWe = 1'b0; assignData = '0;
    lit0.lit_var = '0; lit0.lit_neg = 1'b0;
    lit1.lit_var = '0; lit1.lit_neg = 1'b0;
    idleLit();
    test_reset();
    test_sat_formula();
    test_unsat_and_early_exit();
    test_backpressure_idx();
    test_control();
    test_reset_mid_eval();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
